// File: rtl/decode_stage_if.sv
// Fetch/execute-facing signal bundle of the decode stage.
// master drives the fetch side and consumes the decoded word; slave is the stage itself.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            drain_done;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic            out_branch;
  logic            out_jump;
  logic            out_is_jalr;
  logic [3:0]      out_alu_op;
  logic            out_alu_src_a;
  logic            out_alu_src_b;
  logic            out_reg_write;
  logic            out_mem_read;
  logic            out_mem_write;
  logic            out_mul_div;
  logic [1:0]      out_wb_src;
  logic [2:0]      out_immd_type;
  logic            out_csr_op;
  logic            out_csr_immd;
  logic [2:0]      out_csr_op_type;
  logic [2:0]      out_exc;
  logic            out_fence_i;

  modport master (
    output flush, drain_done, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_branch, out_jump, out_is_jalr,
           out_alu_op, out_alu_src_a, out_alu_src_b, out_reg_write, out_mem_read,
           out_mem_write, out_mul_div, out_wb_src, out_immd_type, out_csr_op,
           out_csr_immd, out_csr_op_type, out_exc, out_fence_i
  );

  modport slave (
    input  flush, drain_done, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_branch, out_jump, out_is_jalr,
           out_alu_op, out_alu_src_a, out_alu_src_b, out_reg_write, out_mem_read,
           out_mem_write, out_mul_div, out_wb_src, out_immd_type, out_csr_op,
           out_csr_immd, out_csr_op_type, out_exc, out_fence_i
  );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I(+M, Zicsr, Zifencei) decode stage with valid/ready handshake,
// flush, and a drain state machine that serialises FENCE.I and (optionally) MRET.
module decode_stage #(
  parameter int XLEN           = 32,
  parameter bit M_EXT          = 1'b1,
  parameter bit ZICSR          = 1'b1,
  parameter bit ZIFENCEI       = 1'b1,
  parameter bit SERIALIZE_MRET = 1'b1
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  typedef struct packed {
    logic       branch;
    logic       jump;
    logic       is_jalr;
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mul_div;
    logic [1:0] wb_src;
    logic [2:0] immd_type;
    logic       csr_op;
    logic       csr_immd;
    logic [2:0] csr_op_type;
    logic [2:0] exc;
    logic       fence_i;
  } ctl_t;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_MISC   = 5'b00011;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_CSR = 2'b11;

  localparam logic [2:0] IMM_I   = 3'b000;
  localparam logic [2:0] IMM_S   = 3'b001;
  localparam logic [2:0] IMM_B   = 3'b010;
  localparam logic [2:0] IMM_U   = 3'b011;
  localparam logic [2:0] IMM_J   = 3'b100;
  localparam logic [2:0] IMM_CSR = 3'b101;

  localparam logic [2:0] CSR_MRET = 3'b110;

  function automatic ctl_t ctl_idle();
    ctl_t c;
    c           = '0;
    c.alu_src_a = 1'b1;
    return c;
  endfunction

  // Base integer ALU encoding; SUB/SRA are selected separately from funct7.
  function automatic logic [3:0] alu_base(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = 4'b0000;
      3'b001:  op = 4'b0010;
      3'b010:  op = 4'b0011;
      3'b011:  op = 4'b0100;
      3'b100:  op = 4'b0101;
      3'b101:  op = 4'b0110;
      3'b110:  op = 4'b1000;
      3'b111:  op = 4'b1001;
      default: op = 4'b0000;
    endcase
    return op;
  endfunction

  state_t          state_r;
  state_t          state_nxt_s;
  logic            out_valid_r;
  logic [31:0]     out_instr_r;
  logic [XLEN-1:0] out_pc_r;
  ctl_t            ctl_r;
  ctl_t            dec_s;
  ctl_t            ctl_s;
  logic            illegal_s;
  logic            in_ready_s;
  logic            accept_s;
  logic            serialize_s;

  logic [4:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [11:0] funct12_s;

  assign opcode_s  = bus.in_instr[6:2];
  assign funct3_s  = bus.in_instr[14:12];
  assign funct7_s  = bus.in_instr[31:25];
  assign funct12_s = bus.in_instr[31:20];

  assign in_ready_s = (state_r == RUN) & (~out_valid_r | bus.out_ready) & ~bus.flush & ~rst;
  assign accept_s   = bus.in_valid & in_ready_s;

  // Combinational decode of the offered instruction word.
  always_comb begin
    dec_s     = ctl_idle();
    illegal_s = 1'b0;
    if (bus.in_instr[1:0] != 2'b11) begin
      illegal_s = 1'b1;
    end else begin
      case (opcode_s)
        OPC_LOAD: begin
          dec_s.wb_src    = WB_MEM;
          dec_s.alu_src_b = 1'b1;
          dec_s.immd_type = IMM_I;
          dec_s.reg_write = 1'b1;
          dec_s.mem_read  = 1'b1;
          illegal_s       = (funct3_s == 3'b011) | (funct3_s[2:1] == 2'b11);
        end
        OPC_STORE: begin
          dec_s.mem_write = 1'b1;
          dec_s.alu_src_b = 1'b1;
          dec_s.immd_type = IMM_S;
          illegal_s       = (funct3_s > 3'b010);
        end
        OPC_AUIPC: begin
          dec_s.alu_src_a = 1'b0;
          dec_s.alu_src_b = 1'b1;
          dec_s.immd_type = IMM_U;
          dec_s.reg_write = 1'b1;
        end
        OPC_LUI: begin
          dec_s.alu_src_b = 1'b1;
          dec_s.immd_type = IMM_U;
          dec_s.alu_op    = 4'b1010;
          dec_s.reg_write = 1'b1;
        end
        OPC_JAL: begin
          dec_s.jump      = 1'b1;
          dec_s.immd_type = IMM_J;
          dec_s.wb_src    = WB_PC4;
          dec_s.reg_write = 1'b1;
        end
        OPC_JALR: begin
          dec_s.jump      = 1'b1;
          dec_s.is_jalr   = 1'b1;
          dec_s.immd_type = IMM_I;
          dec_s.wb_src    = WB_PC4;
          dec_s.reg_write = 1'b1;
        end
        OPC_BRANCH: begin
          dec_s.branch    = 1'b1;
          dec_s.immd_type = IMM_B;
          case (funct3_s[2:1])
            2'b00:   dec_s.alu_op = 4'b0001;
            2'b10:   dec_s.alu_op = 4'b0011;
            2'b11:   dec_s.alu_op = 4'b0100;
            default: illegal_s    = 1'b1;
          endcase
        end
        OPC_OP: begin
          dec_s.reg_write = 1'b1;
          dec_s.alu_src_b = ~bus.in_instr[5];
          case (funct7_s)
            7'b0000000: dec_s.alu_op = alu_base(funct3_s);
            7'b0100000: begin
              case (funct3_s)
                3'b000:  dec_s.alu_op = 4'b0001;
                3'b101:  dec_s.alu_op = 4'b0111;
                default: illegal_s    = 1'b1;
              endcase
            end
            7'b0000001: begin
              if (M_EXT) begin
                dec_s.mul_div = 1'b1;
                dec_s.alu_op  = funct3_s[2] ? 4'b1100 : 4'b1011;
              end else begin
                illegal_s = 1'b1;
              end
            end
            default: illegal_s = 1'b1;
          endcase
        end
        OPC_OPIMM: begin
          // funct7 is immediate data except on the shift encodings.
          dec_s.reg_write = 1'b1;
          dec_s.alu_src_b = ~bus.in_instr[5];
          dec_s.immd_type = IMM_I;
          case (funct3_s)
            3'b001: begin
              dec_s.alu_op = 4'b0010;
              illegal_s    = (funct7_s != 7'b0000000);
            end
            3'b101: begin
              case (funct7_s)
                7'b0000000: dec_s.alu_op = 4'b0110;
                7'b0100000: dec_s.alu_op = 4'b0111;
                default:    illegal_s    = 1'b1;
              endcase
            end
            default: dec_s.alu_op = alu_base(funct3_s);
          endcase
        end
        OPC_MISC: begin
          case (funct3_s)
            3'b000: dec_s.fence_i = 1'b0;
            3'b001: begin
              if (ZIFENCEI) begin
                dec_s.fence_i = 1'b1;
              end else begin
                illegal_s = 1'b1;
              end
            end
            default: illegal_s = 1'b1;
          endcase
        end
        OPC_SYSTEM: begin
          dec_s.wb_src    = WB_CSR;
          dec_s.immd_type = IMM_CSR;
          dec_s.csr_immd  = funct3_s[2];
          case (funct3_s[1:0])
            2'b00: begin
              if (funct3_s[2]) begin
                illegal_s = 1'b1;
              end else begin
                case (funct12_s)
                  12'h000: dec_s.exc[0] = 1'b1;
                  12'h001: dec_s.exc[1] = 1'b1;
                  12'h302: begin
                    if (ZICSR) begin
                      dec_s.csr_op      = 1'b1;
                      dec_s.csr_op_type = CSR_MRET;
                    end else begin
                      illegal_s = 1'b1;
                    end
                  end
                  default: illegal_s = 1'b1;
                endcase
              end
            end
            default: begin
              if (ZICSR) begin
                dec_s.reg_write   = 1'b1;
                dec_s.csr_op      = 1'b1;
                dec_s.csr_op_type = {1'b0, funct3_s[1:0]};
              end else begin
                illegal_s = 1'b1;
              end
            end
          endcase
        end
        default: illegal_s = 1'b1;
      endcase
    end

    // An illegal word must never reach a side-effecting datapath enable.
    ctl_s           = dec_s;
    ctl_s.reg_write = dec_s.reg_write & ~illegal_s;
    ctl_s.mem_read  = dec_s.mem_read & ~illegal_s;
    ctl_s.mem_write = dec_s.mem_write & ~illegal_s;
    ctl_s.branch    = dec_s.branch & ~illegal_s;
    ctl_s.jump      = dec_s.jump & ~illegal_s;
    ctl_s.csr_op    = dec_s.csr_op & ~illegal_s;
    ctl_s.mul_div   = dec_s.mul_div & ~illegal_s;
    ctl_s.fence_i   = dec_s.fence_i & ~illegal_s;
    ctl_s.exc[2]    = illegal_s;
  end

  assign serialize_s = ctl_s.fence_i
                     | (SERIALIZE_MRET & ctl_s.csr_op & (ctl_s.csr_op_type == CSR_MRET));

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Drain FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (accept_s & serialize_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DRAIN: begin
        if (bus.drain_done | bus.flush) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = RUN;
    endcase
  end

  // Output pipeline register; flush takes priority over consume and accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_instr_r <= 32'h0000_0000;
      out_pc_r    <= {XLEN{1'b0}};
      ctl_r       <= ctl_idle();
    end else if (bus.flush) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_instr_r <= bus.in_instr;
      out_pc_r    <= bus.in_pc;
      ctl_r       <= ctl_s;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.in_ready        = in_ready_s;
  assign bus.out_valid       = out_valid_r;
  assign bus.out_instr       = out_instr_r;
  assign bus.out_pc          = out_pc_r;
  assign bus.out_branch      = ctl_r.branch;
  assign bus.out_jump        = ctl_r.jump;
  assign bus.out_is_jalr     = ctl_r.is_jalr;
  assign bus.out_alu_op      = ctl_r.alu_op;
  assign bus.out_alu_src_a   = ctl_r.alu_src_a;
  assign bus.out_alu_src_b   = ctl_r.alu_src_b;
  assign bus.out_reg_write   = ctl_r.reg_write;
  assign bus.out_mem_read    = ctl_r.mem_read;
  assign bus.out_mem_write   = ctl_r.mem_write;
  assign bus.out_mul_div     = ctl_r.mul_div;
  assign bus.out_wb_src      = ctl_r.wb_src;
  assign bus.out_immd_type   = ctl_r.immd_type;
  assign bus.out_csr_op      = ctl_r.csr_op;
  assign bus.out_csr_immd    = ctl_r.csr_immd;
  assign bus.out_csr_op_type = ctl_r.csr_op_type;
  assign bus.out_exc         = ctl_r.exc;
  assign bus.out_fence_i     = ctl_r.fence_i;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected control words are queued at accept
// and compared every cycle the word is presented, then retired on consume/flush/reset.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        branch;
    logic        jump;
    logic        is_jalr;
    logic [3:0]  alu_op;
    logic        alu_src_a;
    logic        alu_src_b;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mul_div;
    logic [1:0]  wb_src;
    logic [2:0]  immd_type;
    logic        csr_op;
    logic        csr_immd;
    logic [2:0]  csr_op_type;
    logic [2:0]  exc;
    logic        fence_i;
  } ctl_t;

  typedef struct {
    ctl_t exp;
    bit   partial;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;
  sb_t  sb_q[$];
  sb_t  head;

  always #5 clk = ~clk;

  // Cycle counter used for throughput measurement.
  always @(posedge clk) cyc <= cyc + 1;

  decode_stage_if #(.XLEN(32)) bus ();
  decode_stage_if #(.XLEN(32)) bus_nm ();

  decode_stage #(.XLEN(32), .M_EXT(1'b1), .ZICSR(1'b1), .ZIFENCEI(1'b1), .SERIALIZE_MRET(1'b1))
    dut (.clk(clk), .rst(rst), .bus(bus));

  decode_stage #(.XLEN(32), .M_EXT(1'b0), .ZICSR(1'b1), .ZIFENCEI(1'b1), .SERIALIZE_MRET(1'b1))
    dut_nm (.clk(clk), .rst(rst), .bus(bus_nm));

  task automatic check_value(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic ctl_t base();
    ctl_t c;
    c           = '0;
    c.alu_src_a = 1'b1;
    return c;
  endfunction

  function automatic ctl_t alu_rw(input logic [3:0] alu, input logic src_b, input logic md);
    ctl_t c;
    c           = base();
    c.alu_op    = alu;
    c.alu_src_b = src_b;
    c.mul_div   = md;
    c.reg_write = 1'b1;
    return c;
  endfunction

  function automatic ctl_t sys(input logic [2:0] exc, input logic csr_op, input logic [2:0] typ,
                               input logic csr_immd, input logic rw);
    ctl_t c;
    c             = base();
    c.wb_src      = 2'b11;
    c.immd_type   = 3'b101;
    c.exc         = exc;
    c.csr_op      = csr_op;
    c.csr_op_type = typ;
    c.csr_immd    = csr_immd;
    c.reg_write   = rw;
    return c;
  endfunction

  function automatic ctl_t observed();
    ctl_t c;
    c.instr       = bus.out_instr;
    c.pc          = bus.out_pc;
    c.branch      = bus.out_branch;
    c.jump        = bus.out_jump;
    c.is_jalr     = bus.out_is_jalr;
    c.alu_op      = bus.out_alu_op;
    c.alu_src_a   = bus.out_alu_src_a;
    c.alu_src_b   = bus.out_alu_src_b;
    c.reg_write   = bus.out_reg_write;
    c.mem_read    = bus.out_mem_read;
    c.mem_write   = bus.out_mem_write;
    c.mul_div     = bus.out_mul_div;
    c.wb_src      = bus.out_wb_src;
    c.immd_type   = bus.out_immd_type;
    c.csr_op      = bus.out_csr_op;
    c.csr_immd    = bus.out_csr_immd;
    c.csr_op_type = bus.out_csr_op_type;
    c.exc         = bus.out_exc;
    c.fence_i     = bus.out_fence_i;
    return c;
  endfunction

  function automatic logic [10:0] enables(input ctl_t c);
    return {c.exc, c.reg_write, c.mem_read, c.mem_write, c.branch, c.jump,
            c.csr_op, c.mul_div, c.fence_i};
  endfunction

  // Compare the presented word every cycle; retire it when it leaves the stage.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_value("sb_spurious", 128'd1, 128'd0);
      end else begin
        head = sb_q[0];
        if (head.partial)
          check_value($sformatf("illegal_%08h", head.exp.instr), enables(observed()), enables(head.exp));
        else
          check_value($sformatf("ctl_%08h", head.exp.instr), observed(), head.exp);
        if (rst || bus.flush || bus.out_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input ctl_t e, input bit partial, output int waits);
    sb_t item;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc_ctr;
    e.instr      = instr;
    e.pc         = pc_ctr;
    item.exp     = e;
    item.partial = partial;
    waits        = 0;
    while (1'b1) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        sb_q.push_back(item);
        break;
      end
      waits++;
      if (waits > 20) begin
        check_value($sformatf("send_timeout_%08h", instr), waits, 0);
        break;
      end
    end
    tick();
    bus.in_valid = 1'b0;
    pc_ctr       = pc_ctr + 32'd4;
  endtask

  task automatic sendc(input logic [31:0] instr, input ctl_t e);
    int w;
    send(instr, e, 1'b0, w);
  endtask

  task automatic send_illegal(input logic [31:0] instr);
    ctl_t e;
    int   w;
    e     = base();
    e.exc = 3'b100;
    send(instr, e, 1'b1, w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ctl_t e;
    int   w;
    int   t0;
    rst = 1'b1;
    bus.flush = 1'b0;    bus.drain_done = 1'b0; bus.in_valid = 1'b0;
    bus.in_instr = 32'h0; bus.in_pc = 32'h0;    bus.out_ready = 1'b1;
    bus_nm.flush = 1'b0; bus_nm.drain_done = 1'b0; bus_nm.in_valid = 1'b0;
    bus_nm.in_instr = 32'h0; bus_nm.in_pc = 32'h0; bus_nm.out_ready = 1'b1;

    repeat (3) tick();
    @(negedge clk);
    check_value("rst_out_valid", bus.out_valid, 1'b0);
    check_value("rst_in_ready", bus.in_ready, 1'b0);
    check_value("rst_ctl", observed(), base());
    tick();
    rst = 1'b0;

    // M_EXT=0 instance: MUL must come out illegal with enables suppressed.
    bus_nm.in_valid = 1'b1;
    bus_nm.in_instr = 32'h023100B3;
    tick();
    bus_nm.in_valid = 1'b0;
    @(negedge clk);
    check_value("nm_valid", bus_nm.out_valid, 1'b1);
    check_value("nm_exc", bus_nm.out_exc, 3'b100);
    check_value("nm_reg_write", bus_nm.out_reg_write, 1'b0);
    check_value("nm_mul_div", bus_nm.out_mul_div, 1'b0);
    tick();

    // Back-to-back stream at full throughput.
    t0 = cyc;
    sendc(32'h003100B3, alu_rw(4'b0000, 1'b0, 1'b0));
    sendc(32'h403100B3, alu_rw(4'b0001, 1'b0, 1'b0));
    sendc(32'h023100B3, alu_rw(4'b1011, 1'b0, 1'b1));
    check_value("b2b_cycles", cyc - t0, 3);

    // Remaining decode classes.
    e = base(); e.wb_src = 2'b01; e.alu_src_b = 1'b1; e.reg_write = 1'b1; e.mem_read = 1'b1;
    sendc(32'h00012083, e);
    e = base(); e.mem_write = 1'b1; e.alu_src_b = 1'b1; e.immd_type = 3'b001;
    sendc(32'h00112023, e);
    e = alu_rw(4'b1010, 1'b1, 1'b0); e.immd_type = 3'b011;
    sendc(32'h123450B7, e);
    e = alu_rw(4'b0000, 1'b1, 1'b0); e.immd_type = 3'b011; e.alu_src_a = 1'b0;
    sendc(32'h00000097, e);
    e = base(); e.jump = 1'b1; e.immd_type = 3'b100; e.wb_src = 2'b10; e.reg_write = 1'b1;
    sendc(32'h0000006F, e);
    e = base(); e.jump = 1'b1; e.is_jalr = 1'b1; e.wb_src = 2'b10; e.reg_write = 1'b1;
    sendc(32'h00008067, e);
    e = base(); e.branch = 1'b1; e.immd_type = 3'b010; e.alu_op = 4'b0011;
    sendc(32'h00004063, e);
    sendc(32'h40115093, alu_rw(4'b0111, 1'b1, 1'b0));

    send_illegal(32'h00000000);
    send_illegal(32'h00002063);
    send_illegal(32'h00003003);
    send_illegal(32'h00004073);
    send_illegal(32'h401010B3);

    sendc(32'h00000073, sys(3'b001, 1'b0, 3'b000, 1'b0, 1'b0));
    sendc(32'h00100073, sys(3'b010, 1'b0, 3'b000, 1'b0, 1'b0));
    sendc(32'h3000E073, sys(3'b000, 1'b1, 3'b010, 1'b1, 1'b1));
    tick();

    // drain_done while running must not disturb the handshake.
    bus.drain_done = 1'b1;
    tick();
    bus.drain_done = 1'b0;
    @(negedge clk);
    check_value("run_ignores_drain_done", bus.in_ready, 1'b1);
    tick();

    // Back-pressure: ADD held for three cycles, SUB waits and is not lost.
    bus.out_ready = 1'b0;
    sendc(32'h003100B3, alu_rw(4'b0000, 1'b0, 1'b0));
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h403100B3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_value("stall_in_ready", bus.in_ready, 1'b0);
      tick();
    end
    bus.out_ready = 1'b1;
    send(32'h403100B3, alu_rw(4'b0001, 1'b0, 1'b0), 1'b0, w);
    check_value("stall_release_wait", w, 0);
    tick();

    // FENCE.I serialises until drain_done.
    e = base(); e.fence_i = 1'b1;
    sendc(32'h0000100F, e);
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h003100B3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_value("drain_in_ready", bus.in_ready, 1'b0);
      tick();
    end
    bus.drain_done = 1'b1;
    @(negedge clk);
    check_value("drain_done_cycle", bus.in_ready, 1'b0);
    tick();
    bus.drain_done = 1'b0;
    send(32'h003100B3, alu_rw(4'b0000, 1'b0, 1'b0), 1'b0, w);
    check_value("resume_wait", w, 0);
    tick();

    // FENCE.I aborted by flush while still presented.
    bus.out_ready = 1'b0;
    e = base(); e.fence_i = 1'b1;
    sendc(32'h0000100F, e);
    @(negedge clk);
    check_value("fence_hold_in_ready", bus.in_ready, 1'b0);
    tick();
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h003100B3;
    @(negedge clk);
    check_value("flush_no_accept", bus.in_ready, 1'b0);
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_value("flush_out_valid", bus.out_valid, 1'b0);
    check_value("flush_run_ready", bus.in_ready, 1'b1);
    tick();

    // MRET enters DRAIN; reset mid-drain clears everything.
    sendc(32'h30200073, sys(3'b000, 1'b1, 3'b110, 1'b0, 1'b0));
    @(negedge clk);
    check_value("mret_drain_ready", bus.in_ready, 1'b0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check_value("rst_drain_in_ready", bus.in_ready, 1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_value("rst_drain_out_valid", bus.out_valid, 1'b0);
    check_value("rst_drain_ready", bus.in_ready, 1'b1);
    tick();
    bus.out_ready = 1'b1;

    repeat (3) tick();
    check_value("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised successor to the combinational instruction decoder.
- Sits between fetch and execute. Accepts one instruction per cycle over a valid/ready handshake and decodes RV32I plus the optional M, Zicsr and Zifencei extensions.
- Presents the control word from a pipeline register.
- Serialises FENCE.I and MRET through a drain state machine, supports flush, and rejects every unknown encoding as illegal.

Parameters:
- XLEN, 32, width of the PC path.
- M_EXT, 1, enable MUL/DIV decode; 0 makes funct7=0000001 on OP illegal.
- ZICSR, 1, enable CSRRW/S/C[I] and MRET; 0 makes every SYSTEM instruction except ECALL/EBREAK illegal.
- ZIFENCEI, 1, enable FENCE.I; 0 makes FENCE.I illegal.
- SERIALIZE_MRET, 1, MRET enters the drain state like FENCE.I.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- flush, input, 1, kill the held instruction and abort serialisation.
- in_valid, input, 1, fetch offers an instruction.
- in_ready, output, 1, stage accepts this cycle.
- in_instr, input, 32, instruction word.
- in_pc, input, XLEN, instruction PC.
- out_valid, output, 1, decoded word is valid.
- out_ready, input, 1, execute consumes.
- out_instr, output, 32, registered instruction.
- out_pc, output, XLEN, registered PC.
- out_branch, out_jump, out_is_jalr, output, 1 each, control-flow flags.
- out_alu_op, output, 4, ALU operation.
- out_alu_src_a, output, 1, 1=rs1, 0=PC.
- out_alu_src_b, output, 1, 1=imm, 0=rs2.
- out_reg_write, out_mem_read, out_mem_write, out_mul_div, output, 1 each, datapath enables.
- out_wb_src, output, 2, 00=ALU, 01=MEM, 10=PC+4, 11=CSR.
- out_immd_type, output, 3, 000=I, 001=S, 010=B, 011=U, 100=J, 101=CSR.
- out_csr_op, out_csr_immd, output, 1 each, CSR access enable and immediate-source select.
- out_csr_op_type, output, 3, 001=RW, 010=RS, 011=RC, 110=MRET.
- out_exc, output, 3, {illegal, ebreak, ecall}.
- out_fence_i, output, 1, instruction is FENCE.I.
- drain_done, input, 1, pulse: downstream pipeline empty and I-cache invalidated.

Behaviour:
- Reset: out_valid=0; all out_* controls=0 except out_alu_src_a=1; FSM=RUN; in_ready=0 during rst.
- Handshake:
  - accept = in_valid & in_ready.
  - in_ready = (state==RUN) & (~out_valid | out_ready) & ~flush.
  - Latency is one cycle: a word accepted in cycle N is on out_* in cycle N+1.
  - Full throughput with out_ready held high.
  - out_* hold stable while out_valid & ~out_ready.
  - out_valid clears on consume unless a new word is accepted in the same cycle.
- Decode table (opcode[6:2]):
  - LOAD: wb=01, src_b=1, I, reg_write, mem_read, alu=0000.
  - STORE: mem_write, src_b=1, S, alu=0000.
  - AUIPC: src_a=0, src_b=1, U, alu=0000, reg_write.
  - LUI: src_b=1, U, alu=1010, reg_write.
  - JAL: jump, J, wb=10, reg_write.
  - JALR: jump, is_jalr, I, wb=10, reg_write.
  - BRANCH: branch, B; alu=0001 for BEQ/BNE, 0011 for BLT/BGE, 0100 for BLTU/BGEU.
  - OP/OP-IMM: reg_write, src_b=~opcode[5]. ALU by funct3: ADD/SUB 0000/0001 (SUB only on OP with funct7[5]); SLL 0010; SLT 0011; SLTU 0100; XOR 0101; SRL/SRA 0110/0111; OR 1000; AND 1001.
  - M (OP, funct7=0000001): mul_div=1; alu=1100 if funct3[2], else 1011.
  - MISC-MEM: FENCE (funct3=000) is a NOP with no enables. FENCE.I (funct3=001) sets out_fence_i.
  - SYSTEM: wb=11, immd=101, csr_immd=funct3[2].
    - funct3[1:0]=01/10/11 gives CSR RW/RS/RC with reg_write and csr_op.
    - funct3=000 with funct12 000 gives ecall; 001 gives ebreak; 302 gives MRET (csr_op, type 110).
- Illegal (out_exc[2]=1):
  - opcode[1:0]!=11, or an unlisted opcode.
  - BRANCH funct3 010/011; LOAD funct3 011/110/111; STORE funct3>010.
  - OP funct7 not in {0000000, 0100000 (ADD/SUB, SRL/SRA only), 0000001 (only if M_EXT)}.
  - OP-IMM shifts with a bad funct7; SYSTEM funct3=100; an unknown funct12 with funct3=000.
  - Any instruction whose extension parameter is 0.
  - When illegal is set, reg_write, mem_*, branch, jump, csr_op, mul_div and out_fence_i are forced to 0.
- FSM:
  - RUN→DRAIN on accepting FENCE.I, or MRET when SERIALIZE_MRET=1.
  - DRAIN→RUN on drain_done or flush.
  - In DRAIN, in_ready=0 while the serialising word still presents and drains normally.
  - drain_done while in RUN is ignored.
- Flush:
  - Next cycle out_valid=0 and FSM=RUN.
  - No accept in the flush cycle.
  - Flush beats out_ready.
- rst overrides everything, including mid-DRAIN.

Test Plan:
- Back-to-back stream 0x003100B3 (ADD), 0x403100B3 (SUB), 0x023100B3 (MUL) with out_ready=1 → one result per cycle; alu_op 0000, 0001, 1011; mul_div=0, 0, 1; reg_write=1 throughout.
- Same MUL with M_EXT=0 → out_exc=100, reg_write=0, mul_div=0. Instruction 0x00000000 → illegal.
- out_ready low for 3 cycles holding ADD → in_ready=0, out_* stable, no word lost; the next word appears one cycle after out_ready rises.
- FENCE.I 0x0000100F → out_fence_i=1, in_ready=0 until drain_done; accept resumes the cycle after drain_done. Repeat with flush instead of drain_done → RUN, out_valid=0.
- ECALL 0x00000073 → out_exc=001. EBREAK 0x00100073 → 010. MRET 0x30200073 → csr_op=1, type 110, enters DRAIN. CSRRSI 0x3000E073 → type 010, csr_immd=1, wb=11.
- Assert rst during DRAIN with out_valid=1 → next cycle out_valid=0, FSM=RUN, in_ready=1 after rst drops.
